// File: rtl/gcd_engine.sv
// gcd_engine
//   Computes gcd(a_i, b_i) by repeated subtraction of the smaller operand
//   from the larger one. A zero operand is resolved directly, without
//   entering the subtract loop. The engine also reports how many
//   subtractions the last completed computation took.
//
//   Ports
//     clk_i         rising-edge clock
//     rst_i         synchronous, active-high reset
//     start_i       request, accepted only while ready_o is high
//     abort_i       cancels an in-flight computation (CALC only)
//     a_i, b_i      operands, sampled on the accepting edge
//     ready_o       idle and able to accept start_i
//     busy_o        computation in flight
//     done_o        one-cycle pulse; result_o/iter_count_o valid from here
//     result_o      last completed GCD, held until the next done_o
//     iter_count_o  subtractions of the last completed computation
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] iter_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] iterCount_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // Compare and both subtraction directions are formed in parallel; the
  // controller only picks the one that takes larger minus smaller, so the
  // chosen difference can never wrap.
  logic             aEqB;
  logic             aGtB;
  logic [WIDTH-1:0] aMinusB;
  logic [WIDTH-1:0] bMinusA;
  logic             opZero;

  assign aEqB    = (a_q == b_q);
  assign aGtB    = (a_q > b_q);
  assign aMinusB = a_q - b_q;
  assign bMinusA = b_q - a_q;
  assign opZero  = (a_i == '0) || (b_i == '0);

  // Controller and datapath share one clocked process. The status flags are
  // registered alongside the state so that each is a flop output, and they
  // are always set together with the state they describe, which keeps
  // ready/busy/done mutually exclusive. result/iterCount are only written on
  // the transition into DONE, so an abort or reset never publishes a partial
  // answer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      iterCount_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort is not looked at here, so start always wins over it
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (opZero) begin
              // gcd(x,0) = x and gcd(0,0) = 0, both equal to a | b
              result_q    <= a_i | b_i;
              iterCount_q <= '0;
              state_q     <= DONE;
              done_q      <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end

        CALC: begin
          if (abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (aEqB) begin
            result_q    <= a_q;
            iterCount_q <= cnt_q;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (aGtB) begin
            a_q   <= aMinusB;
            cnt_q <= cnt_q + ONE;
          end else begin
            b_q   <= bMinusA;
            cnt_q <= cnt_q + ONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign iter_count_o = iterCount_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine
//   Directed checks on an 8-bit engine (timing, ignored starts, zero
//   operands, abort, mid-operation reset) and reference-model checks on a
//   16-bit engine over 1000 operand pairs.
module tb_gcd_engine;

  logic clk;

  // 8-bit instance signals
  logic       rst8, start8, abort8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8;
  logic [7:0] result8, iter8;

  // 16-bit instance signals
  logic        rst16, start16, abort16;
  logic [15:0] a16, b16;
  logic        ready16, busy16, done16;
  logic [15:0] result16, iter16;

  int vectorCount = 0;
  int missCount   = 0;

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk_i        (clk),
    .rst_i        (rst8),
    .start_i      (start8),
    .abort_i      (abort8),
    .a_i          (a8),
    .b_i          (b8),
    .ready_o      (ready8),
    .busy_o       (busy8),
    .done_o       (done8),
    .result_o     (result8),
    .iter_count_o (iter8)
  );

  gcd_engine #(.WIDTH(16)) dut16 (
    .clk_i        (clk),
    .rst_i        (rst16),
    .start_i      (start16),
    .abort_i      (abort16),
    .a_i          (a16),
    .b_i          (b16),
    .ready_o      (ready16),
    .busy_o       (busy16),
    .done_o       (done16),
    .result_o     (result16),
    .iter_count_o (iter16)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; everything is driven and
  // sampled at that point, well away from the edge itself.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every vector and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference GCD by repeated subtraction, with the subtraction count
  function automatic void gcdModel(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] res, output int iters);
    logic [15:0] x, y;
    x = a;
    y = b;
    iters = 0;
    if (x == 16'd0 || y == 16'd0) begin
      res = x | y;
      return;
    end
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
      iters++;
    end
    res = x;
  endfunction

  // One 8-bit operation from cycle 0 through done and back to ready; the
  // done cycle, result and count are compared with hand-computed values.
  task automatic applyStimulus(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic abortAtStart,
                               input int expCycle, input logic [7:0] expRes,
                               input logic [7:0] expIter);
    int cyc;
    stepCycle();
    start8 = 1'b1;
    abort8 = abortAtStart;
    a8 = a;
    b8 = b;
    checkOutput({tag, "_ready_at_start"}, 32'(ready8), 32'd1);
    cyc = 0;
    do begin
      stepCycle();
      cyc++;
      start8 = 1'b0;
      abort8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end while (!done8 && cyc < expCycle + 10);
    checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(expCycle));
    checkOutput({tag, "_result"}, 32'(result8), 32'(expRes));
    checkOutput({tag, "_iter"}, 32'(iter8), 32'(expIter));
    stepCycle();
    checkOutput({tag, "_ready_after"}, 32'(ready8), 32'd1);
    checkOutput({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
  endtask

  // One 16-bit operation checked against the reference model
  task automatic runOp16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] expRes;
    int          expIter;
    int          expCycle;
    int          cyc;
    gcdModel(a, b, expRes, expIter);
    expCycle = (a == 16'd0 || b == 16'd0) ? 1 : expIter + 2;
    stepCycle();
    start16 = 1'b1;
    a16 = a;
    b16 = b;
    cyc = 0;
    do begin
      stepCycle();
      cyc++;
      start16 = 1'b0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
    end while (!done16 && cyc < expCycle + 10);
    if (cyc != expCycle || result16 != expRes || 32'(iter16) != 32'(expIter))
      $display("[TB] operands a=%0d b=%0d", a, b);
    checkOutput("rnd_done_cycle", 32'(cyc), 32'(expCycle));
    checkOutput("rnd_result", 32'(result16), 32'(expRes));
    checkOutput("rnd_iter", 32'(iter16), 32'(expIter));
  endtask

  initial begin
    int doneCount;
    int doneCycle;
    logic [15:0] spA [6];
    logic [15:0] spB [6];
    logic [15:0] ra, rb, rRes;
    int rIter;
    bit ok;

    rst8 = 1'b1;  start8 = 1'b0;  abort8 = 1'b0;  a8 = '0;  b8 = '0;
    rst16 = 1'b1; start16 = 1'b0; abort16 = 1'b0; a16 = '0; b16 = '0;
    stepCycle();
    stepCycle();
    rst8 = 1'b0;
    rst16 = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(ready8), 32'd1);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_result", 32'(result8), 32'd0);
    checkOutput("rst_iter", 32'(iter8), 32'd0);

    // 12,8: busy in cycles 1-3, done in 4 with 4/2, ready in 5
    $display("[TB] basic timing 12,8");
    stepCycle();
    start8 = 1'b1; a8 = 8'd12; b8 = 8'd8;
    for (int c = 1; c <= 5; c++) begin
      stepCycle();
      start8 = 1'b0;
      checkOutput($sformatf("t1_busy_c%0d", c), 32'(busy8), (c <= 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1_done_c%0d", c), 32'(done8), (c == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1_ready_c%0d", c), 32'(ready8), (c == 5) ? 32'd1 : 32'd0);
      if (c == 4) begin
        checkOutput("t1_result", 32'(result8), 32'd4);
        checkOutput("t1_iter", 32'(iter8), 32'd2);
      end
    end

    // 255,1: done in cycle 256, starts in cycles 10 and 100 are ignored
    $display("[TB] long run 255,1 with ignored starts");
    stepCycle();
    start8 = 1'b1; a8 = 8'd255; b8 = 8'd1;
    doneCount = 0;
    doneCycle = -1;
    for (int c = 1; c <= 300; c++) begin
      stepCycle();
      if (done8) begin
        doneCount++;
        doneCycle = c;
        checkOutput("t2_result_at_done", 32'(result8), 32'd1);
        checkOutput("t2_iter_at_done", 32'(iter8), 32'd254);
      end
      start8 = (c == 10 || c == 100);
      a8 = 8'd6;
      b8 = 8'd4;
    end
    start8 = 1'b0;
    checkOutput("t2_done_count", 32'(doneCount), 32'd1);
    checkOutput("t2_done_cycle", 32'(doneCycle), 32'd256);
    checkOutput("t2_result_held", 32'(result8), 32'd1);
    checkOutput("t2_iter_held", 32'(iter8), 32'd254);

    $display("[TB] zero and equal operands");
    applyStimulus("z_0_9", 8'd0, 8'd9, 1'b0, 1, 8'd9, 8'd0);
    applyStimulus("z_0_0", 8'd0, 8'd0, 1'b0, 1, 8'd0, 8'd0);
    applyStimulus("z_7_7", 8'd7, 8'd7, 1'b0, 2, 8'd7, 8'd0);
    applyStimulus("z_9_0", 8'd9, 8'd0, 1'b0, 1, 8'd9, 8'd0);

    // start together with abort in IDLE: start wins (6,4 -> 2 after 2 subs)
    $display("[TB] start with abort in idle");
    applyStimulus("sa_6_4", 8'd6, 8'd4, 1'b1, 4, 8'd2, 8'd2);

    $display("[TB] abort");
    applyStimulus("ab_12_8", 8'd12, 8'd8, 1'b0, 4, 8'd4, 8'd2);
    stepCycle();
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
    doneCount = 0;
    for (int c = 1; c <= 5; c++) begin
      stepCycle();
      start8 = 1'b0;
      if (done8) doneCount++;
      if (c == 5) begin
        checkOutput("ab_busy_c5", 32'(busy8), 32'd1);
        abort8 = 1'b1;
      end
    end
    stepCycle();
    abort8 = 1'b0;
    checkOutput("ab_ready_c6", 32'(ready8), 32'd1);
    checkOutput("ab_busy_c6", 32'(busy8), 32'd0);
    checkOutput("ab_done_c6", 32'(done8), 32'd0);
    for (int c = 7; c <= 40; c++) begin
      stepCycle();
      if (done8) doneCount++;
    end
    checkOutput("ab_no_done", 32'(doneCount), 32'd0);
    checkOutput("ab_result_held", 32'(result8), 32'd4);
    checkOutput("ab_iter_held", 32'(iter8), 32'd2);

    $display("[TB] reset mid-operation");
    stepCycle();
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    doneCount = 0;
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      start8 = 1'b0;
      if (done8) doneCount++;
      if (c == 4) begin
        checkOutput("rm_busy_c4", 32'(busy8), 32'd1);
        rst8 = 1'b1;
      end
    end
    stepCycle();
    rst8 = 1'b0;
    checkOutput("rm_ready", 32'(ready8), 32'd1);
    checkOutput("rm_busy", 32'(busy8), 32'd0);
    checkOutput("rm_done", 32'(done8), 32'd0);
    checkOutput("rm_result", 32'(result8), 32'd0);
    checkOutput("rm_iter", 32'(iter8), 32'd0);
    checkOutput("rm_no_done", 32'(doneCount), 32'd0);
    applyStimulus("rm_21_6", 8'd21, 8'd6, 1'b0, 6, 8'd3, 8'd4);

    // 16-bit: boundary pairs first, then random pairs whose subtraction
    // count stays small enough to keep the run short
    $display("[TB] 16-bit model comparison");
    spA = '{16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF};
    spB = '{16'hFFFF, 16'd0, 16'hFFFF, 16'd0, 16'd21845, 16'hFF00};
    for (int i = 0; i < 1000; i++) begin
      if (i < 6) begin
        ra = spA[i];
        rb = spB[i];
      end else begin
        ok = 1'b0;
        ra = '0;
        rb = '0;
        for (int t = 0; t < 32; t++) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          if ($urandom_range(15) == 0)      ra = 16'd0;
          else if ($urandom_range(15) == 0) rb = 16'd0;
          gcdModel(ra, rb, rRes, rIter);
          if (rIter <= 48) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) rb = ra;
      end
      runOp16(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
